// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for an external 8-deep FIFO: round-robin write grants for three
// requesters, with reads taking priority, occupancy tracking and registered strobes.
module fifo_wr_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   input  logic [7:0] data2,
   input  logic       rd_req,
   output logic       fifo_wen,
   output logic       fifo_ren,
   output logic [7:0] fifo_din,
   output logic [2:0] gnt,
   output logic       rd_ack,
   output logic       rd_valid,
   output logic       rd_err,
   output logic [3:0] count,
   output logic       full,
   output logic       empty
);

   localparam logic [3:0] DEPTH = 4'd8;

   logic [1:0] last;
   logic [1:0] next1;
   logic [1:0] next2;
   logic [1:0] winner;
   logic [7:0] win_data;
   logic       read_go;
   logic       write_go;

   always_comb begin
      // NOTE: every signal gets a default first, so no path through this block infers a latch.
      next1    = (last == 2'd2) ? 2'd0 : last + 2'd1;
      next2    = (next1 == 2'd2) ? 2'd0 : next1 + 2'd1;
      winner   = last;
      win_data = data0;

      // Later assignments win, so the nearest index after last has top priority.
      if (req[next2]) winner = next2;
      if (req[next1]) winner = next1;

      case (winner)
         2'd1:    win_data = data1;
         2'd2:    win_data = data2;
         default: win_data = data0;
      endcase

      read_go  = rd_req && (count != 4'd0);
      write_go = !read_go && (req != 3'b000) && (count != DEPTH);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fifo_wen <= 1'b0;
         fifo_ren <= 1'b0;
         fifo_din <= 8'h00;
         gnt      <= 3'b000;
         rd_ack   <= 1'b0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         count    <= 4'd0;
         last     <= 2'd2;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         fifo_wen <= write_go;
         fifo_ren <= read_go;
         rd_ack   <= read_go;
         rd_err   <= rd_req && (count == 4'd0);
         rd_valid <= fifo_ren;
         gnt      <= 3'b000;

         if (write_go) begin
            gnt      <= 3'b001 << winner;
            fifo_din <= win_data;
            last     <= winner;
            count    <= count + 4'd1;
         end else if (read_go) begin
            count    <= count - 4'd1;
         end
      end
   end

   assign full  = (count == DEPTH);
   assign empty = (count == 4'd0);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a queue-based model predicts each edge's outputs,
// and a monitor compares them, including FIFO data order through a small FIFO stand-in.
module tb_fifo_wr_arbiter;

   typedef struct {
      logic [2:0] gnt;
      logic       wen;
      logic       ren;
      logic [7:0] din;
      logic       ack;
      logic       valid;
      logic       err;
      logic [3:0] count;
      logic       full;
      logic       empty;
      logic       dout_chk;
      logic [7:0] dout;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] req = 3'b000;
   logic [7:0] data0 = 8'h00;
   logic [7:0] data1 = 8'h00;
   logic [7:0] data2 = 8'h00;
   logic       rd_req = 1'b0;
   logic       fifo_wen;
   logic       fifo_ren;
   logic [7:0] fifo_din;
   logic [2:0] gnt;
   logic       rd_ack;
   logic       rd_valid;
   logic       rd_err;
   logic [3:0] count;
   logic       full;
   logic       empty;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t sb[$];

   // Model state
   int         m_count = 0;
   int         m_last  = 2;
   logic [7:0] m_din   = 8'h00;
   logic       m_ren_prev = 1'b0;
   logic [7:0] m_pending = 8'h00;
   logic [7:0] m_q[$];

   // FIFO stand-in fed by the DUT's strobes
   logic [7:0] mem [8];
   logic [2:0] wp;
   logic [2:0] rp;
   logic [7:0] dout;

   fifo_wr_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .data0    (data0),
      .data1    (data1),
      .data2    (data2),
      .rd_req   (rd_req),
      .fifo_wen (fifo_wen),
      .fifo_ren (fifo_ren),
      .fifo_din (fifo_din),
      .gnt      (gnt),
      .rd_ack   (rd_ack),
      .rd_valid (rd_valid),
      .rd_err   (rd_err),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_n) begin
         wp   <= 3'd0;
         rp   <= 3'd0;
         dout <= 8'h00;
      end else begin
         if (fifo_wen) begin
            mem[wp] <= fifo_din;
            wp      <= wp + 3'd1;
         end
         if (fifo_ren) begin
            dout <= mem[rp];
            rp   <= rp + 3'd1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   function automatic int pick(input int last_i, input logic [2:0] r);
      for (int k = 1; k <= 3; k++) begin
         int i;
         i = (last_i + k) % 3;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   // Drive one cycle of stimulus and predict the outputs after the following edge.
   task automatic step(input logic rst, input logic [2:0] r, input logic rd,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      exp_t       e;
      logic [7:0] d [3];
      int         w;
      @(negedge clk);
      rst_n  = rst;
      req    = r;
      rd_req = rd;
      data0  = a;
      data1  = b;
      data2  = c;
      d[0] = a;
      d[1] = b;
      d[2] = c;

      e.gnt = 3'b000; e.wen = 1'b0; e.ren = 1'b0; e.ack = 1'b0; e.err = 1'b0;
      e.valid = 1'b0; e.dout_chk = 1'b0; e.dout = 8'h00;

      if (!rst) begin
         m_count    = 0;
         m_last     = 2;
         m_din      = 8'h00;
         m_ren_prev = 1'b0;
         m_q.delete();
      end else begin
         e.valid    = m_ren_prev;
         e.dout_chk = m_ren_prev;
         e.dout     = m_pending;
         if (rd && m_count > 0) begin
            e.ren = 1'b1;
            e.ack = 1'b1;
            m_pending = m_q.pop_front();
            m_count--;
         end else begin
            e.err = rd;
            w = pick(m_last, r);
            if (w >= 0 && m_count < 8) begin
               e.gnt = 3'(1 << w);
               e.wen = 1'b1;
               m_din = d[w];
               m_q.push_back(d[w]);
               m_count++;
               m_last = w;
            end
         end
         m_ren_prev = e.ren;
      end
      e.din   = m_din;
      e.count = 4'(m_count);
      e.full  = (m_count == 8);
      e.empty = (m_count == 0);
      sb.push_back(e);
   endtask

   task automatic rnd_step(input logic rst, input logic [2:0] r, input logic rd);
      step(rst, r, rd, 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("gnt",      32'(gnt),      32'(e.gnt));
            check("fifo_wen", 32'(fifo_wen), 32'(e.wen));
            check("fifo_ren", 32'(fifo_ren), 32'(e.ren));
            check("fifo_din", 32'(fifo_din), 32'(e.din));
            check("rd_ack",   32'(rd_ack),   32'(e.ack));
            check("rd_valid", 32'(rd_valid), 32'(e.valid));
            check("rd_err",   32'(rd_err),   32'(e.err));
            check("count",    32'(count),    32'(e.count));
            check("full",     32'(full),     32'(e.full));
            check("empty",    32'(empty),    32'(e.empty));
            if (e.dout_chk) check("dout", 32'(dout), 32'(e.dout));
         end
      end
   end

   initial begin : stimulus
      int p_rd;
      rnd_step(1'b0, 3'b000, 1'b0);
      rnd_step(1'b0, 3'b111, 1'b1);

      // Burst fill from reset, then stall at full
      for (int i = 0; i < 10; i++) rnd_step(1'b1, 3'b111, 1'b0);

      // One read while full, then refill
      rnd_step(1'b1, 3'b111, 1'b1);
      rnd_step(1'b1, 3'b111, 1'b0);
      rnd_step(1'b1, 3'b111, 1'b0);

      // Empty reads
      rnd_step(1'b0, 3'b000, 1'b0);
      for (int i = 0; i < 4; i++) rnd_step(1'b1, 3'b000, 1'b1);

      // Data ordering through the FIFO
      rnd_step(1'b0, 3'b000, 1'b0);
      step(1'b1, 3'b010, 1'b0, 8'h11, 8'hA5, 8'h22);
      step(1'b1, 3'b100, 1'b0, 8'h11, 8'h33, 8'h3C);
      step(1'b1, 3'b000, 1'b1, 8'h00, 8'h00, 8'h00);
      step(1'b1, 3'b000, 1'b1, 8'h00, 8'h00, 8'h00);
      step(1'b1, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00);
      step(1'b1, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00);

      // Read wins over a write at count 3, then the write proceeds
      rnd_step(1'b0, 3'b000, 1'b0);
      for (int i = 0; i < 3; i++) rnd_step(1'b1, 3'b001, 1'b0);
      rnd_step(1'b1, 3'b010, 1'b1);
      rnd_step(1'b1, 3'b010, 1'b0);

      // Mid-operation reset at count 5
      rnd_step(1'b0, 3'b000, 1'b0);
      for (int i = 0; i < 5; i++) rnd_step(1'b1, 3'b111, 1'b0);
      rnd_step(1'b0, 3'b111, 1'b1);
      rnd_step(1'b1, 3'b111, 1'b0);
      rnd_step(1'b1, 3'b111, 1'b0);

      // Random traffic with phase-varying read pressure to visit both full and empty
      p_rd = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) p_rd = $urandom_range(10, 90);
         rnd_step(($urandom_range(0, 199) != 0), 3'($urandom),
                  ($urandom_range(0, 99) < p_rd));
      end

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      #2;
      check("scoreboard_drain", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
